dest_tracker: RTL

DEST_TRACKER -- requirements
Module: dest_tracker

---
 rtl/dest_tracker_if.sv | 32 +++
 rtl/dest_tracker.sv | 105 ++++++++++
 2 files changed

// File: rtl/dest_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dest_tracker_if                                                 |
// | Brief    : D-stage destination/source bundle for dest_tracker.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dest_tracker_if #(
    parameter int AW = 5
);
    logic [AW-1:0] d_dest;
    logic          d_wen;
    logic [1:0]    d_tnew;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [1:0]    rs_tuse;
    logic [1:0]    rt_tuse;
    logic          flush;
    logic          stall;
    logic [1:0]    fwd_rs;
    logic [1:0]    fwd_rt;

    modport master (
        output d_dest, d_wen, d_tnew, rs_addr, rt_addr, rs_tuse, rt_tuse, flush,
        input  stall, fwd_rs, fwd_rt
    );

    modport slave (
        input  d_dest, d_wen, d_tnew, rs_addr, rt_addr, rs_tuse, rt_tuse, flush,
        output stall, fwd_rs, fwd_rt
    );
endinterface
`default_nettype wire

// File: rtl/dest_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dest_tracker                                                    |
// | Brief    : E/M/W destination scoreboard producing stall and forward        |
// |            selects. DEST_TRACKER_FWD_EN enables forwarding.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dest_tracker #(
    parameter int AW = 5
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    dest_tracker_if.slave   bus
);

    // Record index 0 = E, 1 = M, 2 = W
    logic [2:0]           r_valid;
    logic [2:0][AW-1:0]   r_addr;
    logic [2:0][1:0]      r_tnew;

    logic [2:0]           w_rs_hit;
    logic [2:0]           w_rt_hit;
    logic                 w_stall;
    logic [1:0]           w_fwd_rs;
    logic [1:0]           w_fwd_rt;
    logic                 w_bubble;

    function automatic logic [1:0] f_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    always_comb begin
        w_rs_hit = '0;
        w_rt_hit = '0;
        for (int i = 0; i < 3; i++) begin
            w_rs_hit[i] = r_valid[i] && (r_addr[i] == bus.rs_addr) && (bus.rs_addr != '0);
            w_rt_hit[i] = r_valid[i] && (r_addr[i] == bus.rt_addr) && (bus.rt_addr != '0);
        end
    end

`ifdef DEST_TRACKER_FWD_EN
    logic [2:0] w_rs_late;
    logic [2:0] w_rt_late;

    always_comb begin
        w_rs_late = '0;
        w_rt_late = '0;
        for (int i = 0; i < 3; i++) begin
            w_rs_late[i] = w_rs_hit[i] && (r_tnew[i] > bus.rs_tuse);
            w_rt_late[i] = w_rt_hit[i] && (r_tnew[i] > bus.rt_tuse);
        end
        w_stall = (|w_rs_late) || (|w_rt_late);
    end

    // Youngest match wins; select only once its result exists
    always_comb begin
        w_fwd_rs = 2'd0;
        w_fwd_rt = 2'd0;
        if (w_rs_hit[0])      w_fwd_rs = (r_tnew[0] == 2'd0) ? 2'd1 : 2'd0;
        else if (w_rs_hit[1]) w_fwd_rs = (r_tnew[1] == 2'd0) ? 2'd2 : 2'd0;
        else if (w_rs_hit[2]) w_fwd_rs = (r_tnew[2] == 2'd0) ? 2'd3 : 2'd0;
        if (w_rt_hit[0])      w_fwd_rt = (r_tnew[0] == 2'd0) ? 2'd1 : 2'd0;
        else if (w_rt_hit[1]) w_fwd_rt = (r_tnew[1] == 2'd0) ? 2'd2 : 2'd0;
        else if (w_rt_hit[2]) w_fwd_rt = (r_tnew[2] == 2'd0) ? 2'd3 : 2'd0;
    end
`else
    always_comb begin
        w_stall  = (|w_rs_hit) || (|w_rt_hit);
        w_fwd_rs = 2'd0;
        w_fwd_rt = 2'd0;
    end
`endif

    assign w_bubble   = w_stall || bus.flush;
    assign bus.stall  = w_stall;
    assign bus.fwd_rs = w_fwd_rs;
    assign bus.fwd_rt = w_fwd_rt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_tnew  <= '0;
        end else begin
            r_valid[2] <= r_valid[1];
            r_addr[2]  <= r_addr[1];
            r_tnew[2]  <= f_dec(r_tnew[1]);
            r_valid[1] <= r_valid[0];
            r_addr[1]  <= r_addr[0];
            r_tnew[1]  <= f_dec(r_tnew[0]);
            if (w_bubble) begin
                r_valid[0] <= 1'b0;
                r_addr[0]  <= '0;
                r_tnew[0]  <= 2'd0;
            end else begin
                // Writes to register 0 are architecturally discarded
                r_valid[0] <= bus.d_wen && (bus.d_dest != '0);
                r_addr[0]  <= bus.d_dest;
                r_tnew[0]  <= bus.d_tnew;
            end
        end
    end

endmodule
`default_nettype wire
